// File: rtl/out_reg_arbiter.sv
// Round-robin arbiter sharing the OUT_* register write port between NREQ requesters,
// each with a one-deep holding slot. Define OUT_REG_ARB_LOCK_EN to add req_lock sequence locking.
module out_reg_arbiter #(
    parameter int NREQ = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6*NREQ-1:0]    req_addr,
    input  logic [32*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]      req_stb,
`ifdef OUT_REG_ARB_LOCK_EN
    input  logic [NREQ-1:0]      req_lock,
`endif
    output logic [NREQ-1:0]      req_busy,
    output logic [5:0]           out_reg_addr,
    output logic [31:0]          out_reg_data,
    output logic                 out_reg_stb,
    input  logic                 out_reg_busy,
    output logic [1:0]           grant_id,
    output logic                 arb_busy,
    output logic [NREQ-1:0]      overrun
);

    logic [NREQ-1:0] slot_valid_q, slot_valid_d;
    logic [5:0]      slot_addr_q [NREQ];
    logic [5:0]      slot_addr_d [NREQ];
    logic [31:0]     slot_data_q [NREQ];
    logic [31:0]     slot_data_d [NREQ];
    logic [1:0]      rr_ptr_q, rr_ptr_d;
    logic [1:0]      grant_id_q, grant_id_d;
    logic [NREQ-1:0] overrun_q, overrun_d;
    logic            arb_busy_q;

    logic [NREQ-1:0] eligible;
    logic [3:0]      elig4;
    logic            win_found;
    logic [1:0]      win_idx;
    logic [1:0]      cand;
    logic            issue;

`ifdef OUT_REG_ARB_LOCK_EN
    logic            lock_active_q, lock_active_d;
    logic [1:0]      lock_owner_q, lock_owner_d;
    logic [3:0]      lock4;

    always_comb begin
        lock4 = '0;
        lock4[NREQ-1:0] = req_lock;
        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = slot_valid_q[i] && (!lock_active_q || lock_owner_q == 2'(i));
        end
    end

    // The drop is evaluated first so an issue with the lock still held re-arms it.
    always_comb begin
        lock_active_d = lock_active_q;
        lock_owner_d  = lock_owner_q;
        if (lock_active_q && !lock4[lock_owner_q]) begin
            lock_active_d = 1'b0;
        end
        if (issue && lock4[win_idx]) begin
            lock_active_d = 1'b1;
            lock_owner_d  = win_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_active_q <= 1'b0;
            lock_owner_q  <= 2'd0;
        end else begin
            lock_active_q <= lock_active_d;
            lock_owner_q  <= lock_owner_d;
        end
    end
`else
    always_comb begin
        eligible = slot_valid_q;
    end
`endif

    // Scan from rr_ptr with 2-bit wrap; indices >= NREQ are never eligible.
    always_comb begin
        elig4 = '0;
        elig4[NREQ-1:0] = eligible;
        win_found = 1'b0;
        win_idx   = 2'd0;
        cand      = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand = rr_ptr_q + 2'(k);
            if (!win_found && elig4[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        issue = !rst && !out_reg_busy && win_found;
    end

    always_comb begin
        out_reg_stb  = issue;
        out_reg_addr = 6'd0;
        out_reg_data = 32'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (issue && win_idx == 2'(i)) begin
                out_reg_addr = slot_addr_q[i];
                out_reg_data = slot_data_q[i];
            end
        end
    end

    always_comb begin
        slot_valid_d = slot_valid_q;
        overrun_d    = overrun_q;
        rr_ptr_d     = rr_ptr_q;
        grant_id_d   = grant_id_q;
        for (int i = 0; i < NREQ; i++) begin
            slot_addr_d[i] = slot_addr_q[i];
            slot_data_d[i] = slot_data_q[i];
            if (issue && win_idx == 2'(i)) begin
                slot_valid_d[i] = 1'b0;
            end
            // A strobe against a full slot is dropped even if that slot drains this cycle.
            if (req_stb[i]) begin
                if (slot_valid_q[i]) begin
                    overrun_d[i] = 1'b1;
                end else begin
                    slot_valid_d[i] = 1'b1;
                    slot_addr_d[i]  = req_addr[6*i +: 6];
                    slot_data_d[i]  = req_data[32*i +: 32];
                end
            end
        end
        if (issue) begin
            grant_id_d = win_idx;
            rr_ptr_d   = (int'(win_idx) == NREQ - 1) ? 2'd0 : win_idx + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid_q <= '0;
            overrun_q    <= '0;
            rr_ptr_q     <= 2'd0;
            grant_id_q   <= 2'd0;
            arb_busy_q   <= 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                slot_addr_q[i] <= 6'd0;
                slot_data_q[i] <= 32'd0;
            end
        end else begin
            slot_valid_q <= slot_valid_d;
            overrun_q    <= overrun_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_id_q   <= grant_id_d;
            arb_busy_q   <= |slot_valid_d;
            for (int i = 0; i < NREQ; i++) begin
                slot_addr_q[i] <= slot_addr_d[i];
                slot_data_q[i] <= slot_data_d[i];
            end
        end
    end

    assign req_busy = slot_valid_q;
    assign grant_id = grant_id_q;
    assign arb_busy = arb_busy_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_out_reg_arbiter.sv
// Directed bench for out_reg_arbiter (NREQ=2): inputs change on the falling edge,
// outputs are checked 1 ns later, well before the next rising edge.
module tb_out_reg_arbiter;
  localparam int NREQ = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [6*NREQ-1:0] req_addr;
  logic [32*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_stb;
  logic [NREQ-1:0]   req_lock;
  logic [NREQ-1:0]   req_busy;
  logic [5:0]        out_reg_addr;
  logic [31:0]       out_reg_data;
  logic              out_reg_stb;
  logic              out_reg_busy;
  logic [1:0]        grant_id;
  logic              arb_busy;
  logic [NREQ-1:0]   overrun;

  int checks = 0;
  int failures = 0;

  out_reg_arbiter #(.NREQ(NREQ)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_stb      (req_stb),
`ifdef OUT_REG_ARB_LOCK_EN
    .req_lock     (req_lock),
`endif
    .req_busy     (req_busy),
    .out_reg_addr (out_reg_addr),
    .out_reg_data (out_reg_data),
    .out_reg_stb  (out_reg_stb),
    .out_reg_busy (out_reg_busy),
    .grant_id     (grant_id),
    .arb_busy     (arb_busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst_v, input logic busy_v, input logic [1:0] stb_v,
                      input logic [5:0] a0, input logic [31:0] d0,
                      input logic [5:0] a1, input logic [31:0] d1);
    @(negedge clk);
    rst          = rst_v;
    out_reg_busy = busy_v;
    req_stb      = stb_v;
    req_addr     = {a1, a0};
    req_data     = {d1, d0};
    #1;
  endtask

  task automatic idle(input logic busy_v);
    step(1'b0, busy_v, 2'b00, 6'd0, 32'd0, 6'd0, 32'd0);
  endtask

  task automatic chk_out(input string tag, input logic stb, input logic [5:0] a, input logic [31:0] d);
    chk({tag, "_stb"}, 32'(out_reg_stb), 32'(stb));
    chk({tag, "_addr"}, 32'(out_reg_addr), 32'(a));
    chk({tag, "_data"}, out_reg_data, d);
  endtask

  initial begin
    req_lock = '0;
    step(1'b1, 1'b0, 2'b00, 6'd0, 32'd0, 6'd0, 32'd0);
    chk_out("rst_hold", 1'b0, 6'd0, 32'd0);
    step(1'b1, 1'b0, 2'b00, 6'd0, 32'd0, 6'd0, 32'd0);
    chk("rst_req_busy", 32'(req_busy), 32'd0);
    chk("rst_arb_busy", 32'(arb_busy), 32'd0);

    // Single write on requester 0
    step(1'b0, 1'b0, 2'b01, 6'h05, 32'hDEADBEEF, 6'd0, 32'd0);
    chk("w0_cap_stb", 32'(out_reg_stb), 32'd0);
    chk("w0_cap_busy", 32'(req_busy), 32'd0);
    idle(1'b0);
    chk_out("w0_issue", 1'b1, 6'h05, 32'hDEADBEEF);
    chk("w0_req_busy", 32'(req_busy), 32'b01);
    chk("w0_arb_busy", 32'(arb_busy), 32'd1);
    idle(1'b0);
    chk("w0_after_stb", 32'(out_reg_stb), 32'd0);
    chk("w0_after_busy", 32'(req_busy), 32'd0);
    chk("w0_grant", 32'(grant_id), 32'd0);
    chk("w0_after_arb", 32'(arb_busy), 32'd0);

    // Single write on requester 1, max address; returns rr_ptr to 0
    step(1'b0, 1'b0, 2'b10, 6'd0, 32'd0, 6'h3F, 32'hCAFEF00D);
    idle(1'b0);
    chk_out("w1_issue", 1'b1, 6'h3F, 32'hCAFEF00D);
    idle(1'b0);
    chk("w1_grant", 32'(grant_id), 32'd1);

    // Simultaneous strobes
    step(1'b0, 1'b0, 2'b11, 6'h01, 32'h11, 6'h02, 32'h22);
    idle(1'b0);
    chk_out("sim_first", 1'b1, 6'h01, 32'h11);
    chk("sim_busy1", 32'(req_busy), 32'b11);
    idle(1'b0);
    chk_out("sim_second", 1'b1, 6'h02, 32'h22);
    chk("sim_grant0", 32'(grant_id), 32'd0);
    chk("sim_busy2", 32'(req_busy), 32'b10);
    idle(1'b0);
    chk("sim_done_stb", 32'(out_reg_stb), 32'd0);
    chk("sim_grant1", 32'(grant_id), 32'd1);

    // Downstream busy for 5 cycles with both slots full
    step(1'b0, 1'b1, 2'b11, 6'h0A, 32'hA0A0A0A0, 6'h0B, 32'hB0B0B0B0);
    chk_out("bz_cap", 1'b0, 6'd0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      idle(1'b1);
      chk_out("bz_hold", 1'b0, 6'd0, 32'd0);
      chk("bz_slots", 32'(req_busy), 32'b11);
    end
    idle(1'b0);
    chk_out("bz_rel0", 1'b1, 6'h0A, 32'hA0A0A0A0);
    idle(1'b0);
    chk_out("bz_rel1", 1'b1, 6'h0B, 32'hB0B0B0B0);
    idle(1'b0);
    chk("bz_done_stb", 32'(out_reg_stb), 32'd0);
    chk("bz_done_arb", 32'(arb_busy), 32'd0);

    // Overrun on requester 1
    step(1'b0, 1'b1, 2'b10, 6'd0, 32'd0, 6'h11, 32'h11110001);
    step(1'b0, 1'b1, 2'b10, 6'd0, 32'd0, 6'h12, 32'h22220002);
    chk("ov_busy", 32'(req_busy), 32'b10);
    chk("ov_pre", 32'(overrun), 32'd0);
    idle(1'b1);
    chk("ov_set", 32'(overrun), 32'b10);
    chk("ov_held_stb", 32'(out_reg_stb), 32'd0);
    idle(1'b0);
    chk_out("ov_issue", 1'b1, 6'h11, 32'h11110001);
    idle(1'b0);
    chk("ov_none_stb", 32'(out_reg_stb), 32'd0);
    chk("ov_sticky", 32'(overrun), 32'b10);
    chk("ov_empty", 32'(req_busy), 32'd0);

    // Reset with two full slots and downstream busy
    step(1'b0, 1'b1, 2'b11, 6'h30, 32'h30303030, 6'h31, 32'h31313131);
    idle(1'b1);
    chk("rs_full", 32'(req_busy), 32'b11);
    chk("rs_arb", 32'(arb_busy), 32'd1);
    step(1'b1, 1'b1, 2'b00, 6'd0, 32'd0, 6'd0, 32'd0);
    chk_out("rs_in1", 1'b0, 6'd0, 32'd0);
    step(1'b1, 1'b0, 2'b00, 6'd0, 32'd0, 6'd0, 32'd0);
    chk_out("rs_in2", 1'b0, 6'd0, 32'd0);
    idle(1'b0);
    chk("rs_req_busy", 32'(req_busy), 32'd0);
    chk("rs_overrun", 32'(overrun), 32'd0);
    chk("rs_arb_busy", 32'(arb_busy), 32'd0);
    chk("rs_grant", 32'(grant_id), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("rs_quiet", 32'(out_reg_stb), 32'd0);
      idle(1'b0);
    end

`ifdef OUT_REG_ARB_LOCK_EN
    // Requester 1 locks the port for three writes while requester 0 waits
    step(1'b0, 1'b0, 2'b01, 6'h1F, 32'h1F1F1F1F, 6'd0, 32'd0);
    idle(1'b0);
    chk_out("lk_pre", 1'b1, 6'h1F, 32'h1F1F1F1F);
    req_lock = 2'b10;
    step(1'b0, 1'b0, 2'b11, 6'h20, 32'h20202020, 6'h21, 32'h21212121);
    idle(1'b0);
    chk_out("lk_w1a", 1'b1, 6'h21, 32'h21212121);
    step(1'b0, 1'b0, 2'b10, 6'd0, 32'd0, 6'h22, 32'h22222222);
    chk("lk_gap1", 32'(out_reg_stb), 32'd0);
    idle(1'b0);
    chk_out("lk_w1b", 1'b1, 6'h22, 32'h22222222);
    step(1'b0, 1'b0, 2'b10, 6'd0, 32'd0, 6'h23, 32'h23232323);
    chk("lk_gap2", 32'(out_reg_stb), 32'd0);
    idle(1'b0);
    chk_out("lk_w1c", 1'b1, 6'h23, 32'h23232323);
    req_lock = 2'b00;
    idle(1'b0);
    chk("lk_drop", 32'(out_reg_stb), 32'd0);
    idle(1'b0);
    chk_out("lk_w0", 1'b1, 6'h20, 32'h20202020);
    idle(1'b0);
    chk("lk_done", 32'(out_reg_stb), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/out_reg_arbiter.md
Name: out_reg_arbiter

Overview:
Shares the single OUT_* register write port (6-bit address, 32-bit data, stb/busy handshake) between up to four requesters, e.g. the buffer executor and the host bus bridge. Each requester gets a one-deep holding slot, so its single-cycle stb is accepted immediately. Slots are drained to the downstream register bank in round-robin order while the bank is not busy. The block sits between the requesters and the register bank, in place of a direct connection.

Parameters:
NREQ, 2, number of requesters; legal range 1..4.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_addr  in  6*NREQ  requester i register address, bits [6i+5:6i]
req_data  in  32*NREQ  requester i write data, bits [32i+31:32i]
req_stb  in  NREQ  requester i write strobe, one cycle per write
req_busy  out  NREQ  registered; high while slot i is full
out_reg_addr  out  6  combinatorial; downstream register address
out_reg_data  out  32  combinatorial; downstream write data
out_reg_stb  out  1  combinatorial; downstream write strobe
out_reg_busy  in  1  downstream bank busy
grant_id  out  2  registered; index of the last issued requester
arb_busy  out  1  registered; OR of all slot_valid bits
overrun  out  NREQ  registered, sticky; stb received while the slot was full

Interface decision: one clock (clk); reset rst is synchronous and active-high.

Behaviour:
- State per slot i: slot_valid[i], slot_addr[i], slot_data[i]. Round-robin pointer rr_ptr is 2 bits.
- Reset (rst high at a clk edge):
  - All slot_valid, slot_addr, slot_data, rr_ptr, grant_id, overrun and arb_busy are cleared to 0.
  - Combinatorial outputs are 0 while rst is high.
  - A reset mid-transfer discards pending slot contents; nothing is issued in the rst cycle.
- Capture: if req_stb[i] && !slot_valid[i], the slot loads addr/data and slot_valid[i] <= 1.
- req_busy[i] equals slot_valid[i] (registered).
- Protocol violation: req_stb[i] while slot_valid[i] is high.
  - The write is dropped and overrun[i] <= 1 (sticky until rst).
  - The slot contents are unchanged.
  - This applies even when slot i is being issued in the same cycle, because busy was already visible to the requester.
- Issue (combinatorial), in any cycle where !rst, !out_reg_busy and some slot is eligible:
  - Winner w = first eligible index scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - out_reg_stb = 1, out_reg_addr = slot_addr[w], out_reg_data = slot_data[w].
  - At the edge: slot_valid[w] <= 0, rr_ptr <= (w+1) mod NREQ, grant_id <= w.
- Eligible means slot_valid[i] is set. With OUT_REG_ARB_LOCK_EN, the lock restriction below also applies.
- When out_reg_busy is high: no stb is issued; out_reg_addr/data are 0; slots hold; rr_ptr holds.
- Latency: a req_stb in cycle N produces downstream stb no earlier than cycle N+1. req_busy is high from N+1 until the cycle after issue.
- Simultaneous captures on several requesters in one cycle are all accepted (independent slots).
- Fairness: with all slots continuously refilled, the grant sequence is 0,1,..,NREQ-1,0,...
- rr_ptr is 2 bits. Indices >= NREQ are skipped and never granted.
- arb_busy <= |next slot_valid.

Optional Feature:
Macro OUT_REG_ARB_LOCK_EN.
- With the macro defined:
  - Adds input req_lock [NREQ] and internal registers lock_active (1 bit) and lock_owner (2 bits).
  - When requester w is issued while req_lock[w] is high: lock_active <= 1, lock_owner <= w.
  - While lock_active, only slot lock_owner is eligible; other slots hold. This allows atomic multi-register sequences such as axis setup.
  - lock_active <= 0 in any cycle where req_lock[lock_owner] is low.
  - rr_ptr still advances as normal on each issue.
  - Reset clears lock_active and lock_owner.
- Without the macro: the req_lock port and the lock logic are absent; the block is pure round-robin.

Test Plan:
- Reset then single write: req_stb[0] with addr=0x05, data=0xDEADBEEF at cycle 1, out_reg_busy=0 -> out_reg_stb=1 with 0x05/0xDEADBEEF at cycle 2; req_busy[0] high in cycle 2 only; grant_id=0.
- Simultaneous stb on 0 and 1 (addr 0x01/0x02), rr_ptr=0 -> addr 0x01 issued in cycle N+1 and 0x02 in N+2; grant_id goes 0 then 1.
- Hold out_reg_busy=1 for 5 cycles with both slots full -> no out_reg_stb and slots retained; after release, issues resume in round-robin order.
- Send a second req_stb[1] while slot 1 is full -> overrun[1]=1 (sticky), original data issued, second write never appears downstream.
- Assert rst while two slots are full and out_reg_busy=1 -> after rst: no out_reg_stb ever, req_busy=0, overrun=0, arb_busy=0.
- (LOCK_EN) Requester 1 holds req_lock=1 and issues three writes while requester 0 has a slot pending -> all three req1 writes issue consecutively; req0 issues only after req_lock[1] drops.
